// File: rtl/data_ram_sized_pkg.sv
// Shared definitions for the sized data RAM: access-size codes, FSM states
// and the common chip/write-enable constants.
package data_ram_sized_pkg;

    typedef enum logic [1:0] {
        SizeByte   = 2'b00,
        SizeHalf   = 2'b01,
        SizeWord   = 2'b10,
        SizeDouble = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StExec = 2'b10
    } state_e;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [63:0] ZeroWord    = 64'h0;

    localparam int WaitCntW = 4;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/data_ram_sized_if.sv
// Request/response bus between the MEM stage (master) and the data RAM (slave).
interface data_ram_sized_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_lane_align.sv
// Combinational byte-lane steering: store strobes/data placement and
// load extraction with sign or zero extension.
module data_ram_lane_align
    import data_ram_sized_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  i_offset,
    input  size_e             i_size,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_raw,
    input  logic              i_unsigned,
    output logic [STRB_W-1:0] o_strb,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [OFF_W+2:0]  w_bit_off;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_keep;
    logic [DATA_W-1:0] w_fill;
    logic [STRB_W-1:0] w_mask;
    logic              w_sign;

    assign w_bit_off = {i_offset, 3'b000};
    assign w_shifted = i_raw >> w_bit_off;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        w_mask = '1;
        w_keep = '1;
        w_sign = 1'b0;
        unique case (i_size)
            SizeByte: begin
                w_mask = STRB_W'(1);
                w_keep = DATA_W'(8'hFF);
                w_sign = w_shifted[7];
            end
            SizeHalf: begin
                w_mask = STRB_W'(2'b11);
                w_keep = DATA_W'(16'hFFFF);
                w_sign = w_shifted[15];
            end
            SizeWord: begin
                w_mask = STRB_W'(4'hF);
                w_keep = DATA_W'(32'hFFFF_FFFF);
                w_sign = w_shifted[31];
            end
            default: ;
        endcase
    end

    // A full-width access has w_keep all ones, so the fill never shows.
    assign w_fill  = i_unsigned ? '0 : {DATA_W{w_sign}};
    assign o_rdata = (w_shifted & w_keep) | (w_fill & ~w_keep);
    assign o_strb  = w_mask << i_offset;
    assign o_wdata = i_wdata << w_bit_off;

endmodule

// File: rtl/data_ram_sized.sv
// Sized data RAM with valid/ready requests, wait states and a one-cycle
// response pulse. Define DATA_RAM_MISALIGN_TRAP_EN to trap misaligned accesses.
module data_ram_sized
    import data_ram_sized_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    data_ram_sized_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [WaitCntW-1:0] WaitInit =
        (WAIT_STATES > 0) ? WaitCntW'(WAIT_STATES - 1) : '0;

    state_e              r_state;
    state_e              w_next;
    logic [WaitCntW-1:0] r_wait_cnt;

    logic                r_we;
    logic [IDX_W-1:0]    r_idx;
    logic [OFF_W-1:0]    r_off;
    size_e               r_size;
    logic                r_unsigned;
    logic [DATA_W-1:0]   r_wdata;

    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_rdata;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic [OFF_W-1:0]    w_align_mask;
    logic [OFF_W-1:0]    w_off_eff;
    logic                w_illegal;
    logic                w_err;
    logic                w_mem_we;
    logic [STRB_W-1:0]   w_strb;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [DATA_W-1:0]   w_load;

    assign bus.req_ready  = (ce == ChipEnable) && rst_n && (r_state == StIdle);
    assign w_accept       = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_rdata;

    assign w_align_mask = OFF_W'(size_bytes(r_size) - 4'd1);
    assign w_illegal    = (r_size == SizeDouble) && (DATA_W == 32);

`ifdef DATA_RAM_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = |(r_off & w_align_mask);
    assign w_err        = w_illegal || w_misaligned;
    assign w_off_eff    = r_off;
`else
    assign w_err        = w_illegal;
    assign w_off_eff    = r_off & ~w_align_mask;
`endif

    assign w_mem_we = (r_state == StExec) && (r_we == WriteEnable) && !w_err;

    data_ram_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_offset   (w_off_eff),
        .i_size     (r_size),
        .i_wdata    (r_wdata),
        .i_raw      (r_mem[r_idx]),
        .i_unsigned (r_unsigned),
        .o_strb     (w_strb),
        .o_wdata    (w_wdata_sh),
        .o_rdata    (w_load)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_next = (WAIT_STATES > 0) ? StWait : StExec;
            StWait:  if (r_wait_cnt == '0) w_next = StExec;
            StExec:  w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were just before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_wait_cnt <= WaitInit;
            else if (r_state == StWait && r_wait_cnt != '0)
                r_wait_cnt <= r_wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_off      <= '0;
            r_size     <= SizeByte;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_we       <= bus.req_we;
            r_idx      <= bus.req_addr[OFF_W +: IDX_W];
            r_off      <= bus.req_addr[OFF_W-1:0];
            r_size     <= size_e'(bus.req_size);
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= ZeroWord[DATA_W-1:0];
        end else begin
            r_resp_valid <= (r_state == StExec);
            if (r_state == StExec) begin
                r_resp_err <= w_err;
                r_rdata    <= (!w_err && r_we != WriteEnable) ? w_load : ZeroWord[DATA_W-1:0];
            end
        end
    end

    // NOTE: the array has no reset; contents survive rst_n, and an abandoned
    // store cannot land because reset forces the FSM out of EXEC.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) r_mem[r_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
        end
    end

endmodule

// File: doc/data_ram_sized.md
Name: data_ram_sized

Overview:
- Parametrised, clocked data memory that serves the MEM stage through a valid/ready request and single-pulse response interface.
- Supports byte, half, word and (when DATA_W=64) double accesses, with byte-lane write strobes and signed/unsigned load extension.
- Configurable wait states emulate slower memories.
- Replaces the single-width combinational data RAM in the SoC top level.

Parameters:
- DATA_W, 32: memory word width in bits. Legal values are 32 and 64.
- DEPTH, 1024: number of DATA_W words. Must be a power of two.
- ADDR_W, 32: byte-address width. Must satisfy ADDR_W >= log2(DEPTH*DATA_W/8).
- WAIT_STATES, 0: extra cycles inserted between request acceptance and response. Range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  chip enable. While low, no new request is accepted.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  DATA_W  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  load result, right-aligned and extended. Zero for stores and errors.
- resp_err  out  1  access rejected. Valid only when resp_valid=1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - req_ready is 0 while rst_n is low.
  - Memory contents are not cleared.
- req_ready = ce && rst_n && (state==IDLE).
- A request is accepted at a rising edge where req_valid && req_ready.
  - addr, we, size, unsigned and wdata are latched at that edge.
  - Request inputs may change afterwards.
- FSM states:
  - IDLE: on acceptance, go to WAIT if WAIT_STATES>0, else go to EXEC.
  - WAIT: count WAIT_STATES cycles, then go to EXEC.
  - EXEC: one cycle. At the end of EXEC, the store commits, load data is registered, resp_valid is set for the next cycle, and the FSM returns to IDLE.
- Latency: resp_valid is high exactly (2+WAIT_STATES) cycles after the acceptance edge. req_ready is high again in the response cycle.
- Throughput: one access per (2+WAIT_STATES) cycles.
- A load accepted immediately after a store to the same word observes the stored data. The store commits before the load's EXEC, so no forwarding path is needed.
- Address decode:
  - Word index = req_addr[ADDR_W-1 : log2(DATA_W/8)] modulo DEPTH. Upper bits are ignored, so addresses wrap.
  - The byte offset selects the lane.
- Store: the addressed byte lanes are written from the low bits of wdata. All other lanes are unchanged.
- Load: the addressed lanes are shifted down to bit 0.
  - Signed loads (req_unsigned=0) sign-extend from the top bit of the access size.
  - Unsigned loads zero-extend.
  - A full-width load ignores req_unsigned.
- Illegal size (11 with DATA_W=32): resp_err=1, no write, resp_rdata=0.
- ce deasserted while in WAIT or EXEC: the accepted access still completes.
- rst_n asserted mid-operation: the access is abandoned. A store not yet committed is not performed, and no response is produced.

Optional Feature:
- Macro: DATA_RAM_MISALIGN_TRAP_EN
- Defined: an access whose address is not a multiple of its size in bytes completes with resp_err=1, no memory write and resp_rdata=0. Timing is unchanged.
- Undefined: the low address bits are forced to alignment (half clears bit 0, word clears bits 1:0, double clears bits 2:0) and the access proceeds normally with resp_err=0.

Decomposition:
- Shared defs package holds:
  - size codes (SizeByte, SizeHalf, SizeWord, SizeDouble);
  - FSM state encodings;
  - existing ChipEnable/ChipDisable, WriteEnable and ZeroWord constants.
- One sub-module, data_ram_lane_align:
  - combinational;
  - computes byte strobes and shifted store data from (addr offset, size, wdata);
  - computes the extended load result from (raw word, offset, size, unsigned).
- The top module holds the FSM, wait counter, request latch and memory array.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 → resp_valid 2 cycles after each acceptance; rdata=0xDEADBEEF; resp_err=0.
- Store byte 0x80 at 0x11 over 0xDEADBEEF, then signed LB 0x11 → 0xFFFFFF80; LBU 0x11 → 0x00000080; LW 0x10 → 0xDEAD80EF.
- WAIT_STATES=3: load issued with req_valid held → req_ready low for 4 cycles after acceptance; resp_valid exactly 5 cycles after acceptance; a second request is accepted in the response cycle.
- With DATA_RAM_MISALIGN_TRAP_EN: LW at 0x12 → resp_err=1, rdata=0. Without it: LW 0x12 returns the word at 0x10. With DATA_W=32, size 11 → resp_err=1 in both builds.
- rst_n pulled low during WAIT of a store of 0x12345678 to 0x20 → no resp_valid; a later LW 0x20 returns the prior contents.
- Address wrap (DEPTH=1024, DATA_W=32): store word 0xA5A5A5A5 at 0x1000, then load word at 0x0 → 0xA5A5A5A5.
